// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg
// Shared definitions for the RPN stack ALU sequencer: ALU opcode encodings,
// result error codes and the controller state encoding.
// No ports (package).
package stack_alu_pkg;

    // ALU opcodes, sampled by the ALU on a rising clock edge.
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    // Per-expression error codes reported on res_err.
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_UNDER     = 2'b01;
    localparam logic [1:0] ERR_FULL      = 2'b10;
    localparam logic [1:0] ERR_MALFORMED = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_CHECK   = 3'd2,
        S_POP     = 3'd3,
        S_CAPT    = 3'd4,
        S_RESULT  = 3'd5,
        S_DISCARD = 3'd6,
        S_FLUSH   = 3'd7
    } state_t;

endpackage

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer
// Evaluates postfix (RPN) expressions on an external stack ALU. Tokens arrive
// over a valid/ready handshake; the controller tracks the ALU stack depth,
// issues push/add/mul/pop opcodes and returns one result per expression with a
// sticky overflow flag and an error code.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tok_valid/ready   token handshake; tok_is_op, tok_last, tok_data payload
//   alu_opcode        registered ALU opcode (nop/add/mul/push/pop)
//   alu_input_data    registered push operand
//   alu_output_data   ALU top-of-stack result (valid the cycle after the op)
//   alu_overflow      ALU arithmetic overflow (valid the cycle after the op)
//   res_valid/ready   result handshake; res_data, res_overflow, res_err payload
//   busy              controller is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and payload stable until that edge; ready
// may be dropped or raised at any time and does not depend on valid.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic         tok_last,
    input  logic [N-1:0] tok_data,
    output logic [2:0]   alu_opcode,
    output logic [N-1:0] alu_input_data,
    input  logic [N-1:0] alu_output_data,
    input  logic         alu_overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_overflow,
    output logic [1:0]   res_err,
    output logic         busy
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t        state, state_d;
    logic [DW-1:0] depth, depth_d;
    logic [2:0]    opcode_d;
    logic [N-1:0]  input_d;
    logic [N-1:0]  res_data_d;
    logic          sticky_d;
    logic [1:0]    err_d;
    logic          last_q, last_d;     // accepted token was the last one
    logic          arith_q, arith_d;   // accepted token was add/mul

    // Ready is forced low while reset is asserted even though the state
    // register already holds S_IDLE.
    assign tok_ready = rst_n && (state == S_IDLE || state == S_DISCARD);
    assign res_valid = (state == S_RESULT);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_d    = state;
        depth_d    = depth;
        opcode_d   = OP_NOP;
        input_d    = alu_input_data;
        res_data_d = res_data;
        sticky_d   = res_overflow;
        err_d      = res_err;
        last_d     = last_q;
        arith_d    = arith_q;

        case (state)
            S_IDLE: begin
                if (tok_valid && tok_ready) begin
                    last_d = tok_last;
                    if (!tok_is_op) begin
                        if (depth == DEPTH_MAX) begin
                            err_d   = ERR_FULL;
                            state_d = tok_last ? S_FLUSH : S_DISCARD;
                        end else begin
                            arith_d  = 1'b0;
                            input_d  = tok_data;
                            opcode_d = OP_PUSH;
                            state_d  = S_EXEC;
                        end
                    end else begin
                        if (depth < DW'(2)) begin
                            err_d   = ERR_UNDER;
                            state_d = tok_last ? S_FLUSH : S_DISCARD;
                        end else begin
                            arith_d  = 1'b1;
                            opcode_d = tok_data[0] ? OP_MUL : OP_ADD;
                            state_d  = S_EXEC;
                        end
                    end
                end
            end
            S_EXEC: begin
                // The opcode is visible to the ALU for this one cycle.
                depth_d = arith_q ? depth - DW'(1) : depth + DW'(1);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // ALU flags for the op issued in S_EXEC are valid now.
                if (arith_q) begin
                    sticky_d = res_overflow | alu_overflow;
                end
                if (last_q) begin
                    if (depth == DW'(1)) begin
                        opcode_d = OP_POP;
                        state_d  = S_POP;
                    end else begin
                        err_d   = ERR_MALFORMED;
                        state_d = S_FLUSH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                depth_d = '0;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                res_data_d = alu_output_data;
                state_d    = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    sticky_d = 1'b0;
                    err_d    = ERR_OK;
                    state_d  = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (tok_valid && tok_ready && tok_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // A pop is on the bus whenever depth is nonzero here.
                if (depth != '0) begin
                    depth_d = depth - DW'(1);
                end else begin
                    res_data_d = '0;
                    state_d    = S_RESULT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush pops are registered, so the pop for the next flush cycle is
        // decided from the depth that cycle will see.
        if (state_d == S_FLUSH && depth_d != '0) begin
            opcode_d = OP_POP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            depth          <= '0;
            alu_opcode     <= OP_NOP;
            alu_input_data <= '0;
            res_data       <= '0;
            res_overflow   <= 1'b0;
            res_err        <= ERR_OK;
            last_q         <= 1'b0;
            arith_q        <= 1'b0;
        end else begin
            state          <= state_d;
            depth          <= depth_d;
            alu_opcode     <= opcode_d;
            alu_input_data <= input_d;
            res_data       <= res_data_d;
            res_overflow   <= sticky_d;
            res_err        <= err_d;
            last_q         <= last_d;
            arith_q        <= arith_d;
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer
// Bench for stack_alu_sequencer with a behavioural truncating stack ALU.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam logic [8:0] T_ADD = 9'h100;
    localparam logic [8:0] T_MUL = 9'h101;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         tok_valid = 1'b0;
    logic         tok_ready;
    logic         tok_is_op = 1'b0;
    logic         tok_last = 1'b0;
    logic [N-1:0] tok_data = '0;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_input_data;
    logic [N-1:0] alu_output_data;
    logic         alu_overflow;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_data;
    logic         res_overflow;
    logic [1:0]   res_err;
    logic         busy;

    always #5 clk = ~clk;

    stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
        .tok_last(tok_last), .tok_data(tok_data),
        .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
        .alu_output_data(alu_output_data), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_overflow(res_overflow), .res_err(res_err), .busy(busy)
    );

    // ---------------- behavioural ALU ----------------
    logic [N-1:0] alu_stk[$];
    logic [2:0]   op_trace[$];
    int           alu_fault = 0;
    logic [15:0]  alu_a, alu_b, alu_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_stk.delete();
            alu_output_data <= '0;
            alu_overflow    <= 1'b0;
        end else begin
            if (alu_opcode != OP_NOP) op_trace.push_back(alu_opcode);
            case (alu_opcode)
                OP_PUSH: begin
                    if (alu_stk.size() >= DEPTH) alu_fault++;
                    else begin
                        alu_stk.push_back(alu_input_data);
                        alu_output_data <= alu_input_data;
                        alu_overflow    <= 1'b0;
                    end
                end
                OP_ADD, OP_MUL: begin
                    if (alu_stk.size() < 2) alu_fault++;
                    else begin
                        alu_a = 16'(alu_stk.pop_back());
                        alu_b = 16'(alu_stk.pop_back());
                        alu_w = (alu_opcode == OP_ADD) ? alu_a + alu_b : alu_a * alu_b;
                        alu_stk.push_back(alu_w[7:0]);
                        alu_output_data <= alu_w[7:0];
                        alu_overflow    <= |alu_w[15:8];
                    end
                end
                OP_POP: begin
                    if (alu_stk.size() == 0) alu_fault++;
                    else begin
                        alu_output_data <= alu_stk.pop_back();
                        alu_overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0]  cur_tok[12];   // {is_op, data}
    int          cur_n;
    logic [7:0]  m_data;
    logic        m_ovf;
    logic [1:0]  m_err;
    logic [2:0]  exp_q[$];      // expected ALU opcode trace

    function automatic void model();
        int s[$];
        int a, b, r;
        m_ovf = 1'b0;
        m_err = ERR_OK;
        exp_q.delete();
        for (int i = 0; i < cur_n; i++) begin
            if (!cur_tok[i][8]) begin
                if (s.size() == DEPTH) begin m_err = ERR_FULL; break; end
                s.push_back(int'(cur_tok[i][7:0]));
                exp_q.push_back(OP_PUSH);
            end else begin
                if (s.size() < 2) begin m_err = ERR_UNDER; break; end
                a = s.pop_back();
                b = s.pop_back();
                r = cur_tok[i][0] ? a * b : a + b;
                if (r > 255) m_ovf = 1'b1;
                s.push_back(r % 256);
                exp_q.push_back(cur_tok[i][0] ? OP_MUL : OP_ADD);
            end
        end
        if (m_err == ERR_OK && s.size() != 1) m_err = ERR_MALFORMED;
        m_data = (m_err == ERR_OK) ? 8'(s[0]) : 8'h00;
        // A good expression pops its single result; a bad one pops what is left.
        for (int k = 0; k < s.size(); k++) exp_q.push_back(OP_POP);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_tok(input logic [8:0] t, input logic last);
        int cyc = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = t[8];
        tok_data  = t[7:0];
        tok_last  = last;
        while (tok_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (tok_ready !== 1'b1) check("tok_ready_timeout", {31'd0, tok_ready}, 32'd1);
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_last  = 1'b0;
    endtask

    task automatic run_cur(input logic [7:0] ed, input logic eo, input logic [1:0] ee,
                           input int hold, input string name);
        int cyc = 0;
        int bad = 0;
        op_trace.delete();
        for (int j = 0; j < cur_n; j++) send_tok(cur_tok[j], (j == cur_n - 1));
        while (res_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({name, ".res_valid"}, {31'd0, res_valid}, 32'd1);
        check({name, ".res_data"}, {24'd0, res_data}, {24'd0, ed});
        check({name, ".res_overflow"}, {31'd0, res_overflow}, {31'd0, eo});
        check({name, ".res_err"}, {30'd0, res_err}, {30'd0, ee});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, {31'd0, res_valid}, 32'd1);
            check({name, ".hold_data"}, {24'd0, res_data}, {24'd0, ed});
            check({name, ".hold_err"}, {30'd0, res_err}, {30'd0, ee});
            check({name, ".hold_tok_ready"}, {31'd0, tok_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check({name, ".post_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({name, ".post_tok_ready"}, {31'd0, tok_ready}, 32'd1);
        check({name, ".post_busy"}, {31'd0, busy}, 32'd0);
        check({name, ".trace_len"}, op_trace.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < op_trace.size() && op_trace[k] !== exp_q[k]) bad++;
        check({name, ".trace"}, bad, 0);
        check({name, ".alu_depth"}, alu_stk.size(), 0);
        check({name, ".alu_fault"}, alu_fault, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0]       n;
        logic [11:0][8:0] tok;
        logic [7:0]       exp_data;
        logic             exp_ovf;
        logic [1:0]       exp_err;
    } vec_t;

    localparam int NROWS = 9;
    vec_t       tbl[NROWS];
    logic [8:0] row_q[$];

    function automatic logic [8:0] opnd(input logic [7:0] v);
        return {1'b0, v};
    endfunction

    task automatic put_row(input int idx, input logic [7:0] ed, input logic eo, input logic [1:0] ee);
        tbl[idx].n   = 4'(row_q.size());
        tbl[idx].tok = '0;
        foreach (row_q[k]) tbl[idx].tok[k] = row_q[k];
        tbl[idx].exp_data = ed;
        tbl[idx].exp_ovf  = eo;
        tbl[idx].exp_err  = ee;
    endtask

    task automatic load_tokens();
        for (int j = 0; j < row_q.size(); j++) cur_tok[j] = row_q[j];
        cur_n = row_q.size();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.tok_ready", {31'd0, tok_ready}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.res_valid", {31'd0, res_valid}, 32'd0);
        check("reset.alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("reset.alu_input_data", {24'd0, alu_input_data}, 32'd0);
        check("reset.res_data", {24'd0, res_data}, 32'd0);
        check("reset.res_overflow", {31'd0, res_overflow}, 32'd0);
        check("reset.res_err", {30'd0, res_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.tok_ready", {31'd0, tok_ready}, 32'd1);

        row_q = '{opnd(8'h03), opnd(8'h04), T_ADD};                        put_row(0, 8'h07, 1'b0, ERR_OK);
        row_q = '{opnd(8'hEB), opnd(8'h0A), T_MUL};                        put_row(1, 8'h2E, 1'b1, ERR_OK);
        row_q = '{opnd(8'h05), T_ADD};                                     put_row(2, 8'h00, 1'b0, ERR_UNDER);
        row_q = '{opnd(8'd1), opnd(8'd2), opnd(8'd3), opnd(8'd4), opnd(8'd5),
                  opnd(8'd6), opnd(8'd7), opnd(8'd8), opnd(8'd9)};         put_row(3, 8'h00, 1'b0, ERR_FULL);
        row_q = '{opnd(8'h01), opnd(8'h02), T_ADD};                        put_row(4, 8'h03, 1'b0, ERR_OK);
        row_q = '{opnd(8'h02), opnd(8'h03), T_MUL, opnd(8'h04), T_ADD};    put_row(5, 8'h0A, 1'b0, ERR_OK);
        row_q = '{opnd(8'hC8), opnd(8'h64), T_ADD};                        put_row(6, 8'h2C, 1'b1, ERR_OK);
        row_q = '{T_ADD, opnd(8'h05), opnd(8'h06)};                        put_row(7, 8'h00, 1'b0, ERR_UNDER);
        row_q = '{opnd(8'hFF), opnd(8'hFF), T_MUL, opnd(8'h01), T_ADD};    put_row(8, 8'h02, 1'b1, ERR_OK);

        for (int i = 0; i < NROWS; i++) begin
            cur_n = int'(tbl[i].n);
            for (int j = 0; j < 12; j++) cur_tok[j] = tbl[i].tok[j];
            model();
            run_cur(tbl[i].exp_data, tbl[i].exp_ovf, tbl[i].exp_err, 0, $sformatf("row%0d", i));
        end

        // Malformed end with a stalled consumer.
        row_q = '{opnd(8'h01), opnd(8'h02)};
        load_tokens();
        model();
        run_cur(8'h00, 1'b0, ERR_MALFORMED, 5, "stall");

        // Reset while the second token is executing.
        op_trace.delete();
        send_tok(opnd(8'h06), 1'b0);
        send_tok(opnd(8'h07), 1'b0);   // returns 1 time unit into S_EXEC
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("midrst.alu_input_data", {24'd0, alu_input_data}, 32'd0);
        check("midrst.tok_ready", {31'd0, tok_ready}, 32'd0);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst.res_data", {24'd0, res_data}, 32'd0);
        check("midrst.res_err", {30'd0, res_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.release_ready", {31'd0, tok_ready}, 32'd1);
        row_q = '{opnd(8'h06), opnd(8'h07), T_ADD};
        load_tokens();
        model();
        run_cur(8'd13, 1'b0, ERR_OK, 0, "after_rst");

        // Randomized expressions against the reference model.
        for (int r = 0; r < 30; r++) begin
            int cnt = 0;
            cur_n = $urandom_range(1, 10);
            for (int j = 0; j < cur_n; j++) begin
                bit want_op = (cnt >= 2) && ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 11) == 0) want_op = !want_op;
                if (want_op) begin
                    cur_tok[j] = {1'b1, 7'd0, 1'($urandom_range(0, 1))};
                    cnt--;
                end else begin
                    cur_tok[j] = {1'b0, 8'($urandom_range(0, 255))};
                    cnt++;
                end
            end
            model();
            run_cur(m_data, m_ovf, m_err, $urandom_range(0, 2), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
